dm_sba_master: RTL and testbench

Bus-master stage of the System Bus Access (SBA) path, directly downstream of the `dm_sba_top` register front-end. It receives the trigger pulses and the sbaddress/sbdata/sbaccess/sbautoincrement fields from the front-end and runs one single-beat transfer on a 32-bit req/gnt/rvalid system bus. It returns read data, busy, error codes and auto-incremented addresses to the front-end.

---
 rtl/dm_pkg.sv | 37 +++
 rtl/dm_sba_lane.sv | 44 ++++
 rtl/dm_sba_master.sv | 179 +++++++++++++++++
 tb/tb_dm_sba_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types for the debug-module system bus access path.
// Error codes, bus-master FSM states, access sizes, alignment helper.
package dm_pkg;

   typedef enum logic [2:0] {
      SBERR_NONE    = 3'd0,
      SBERR_TIMEOUT = 3'd1,
      SBERR_BADADDR = 3'd2,
      SBERR_ALIGN   = 3'd3,
      SBERR_SIZE    = 3'd4
   } sberror_e;

   typedef enum logic [1:0] {
      SBA_IDLE,
      SBA_REQ,
      SBA_WAIT,
      SBA_DONE
   } sba_state_e;

   localparam logic [1:0] SZ_8  = 2'd0;
   localparam logic [1:0] SZ_16 = 2'd1;
   localparam logic [1:0] SZ_32 = 2'd2;

   function automatic logic sba_misaligned(
      input logic [2:0] acc,
      input logic [1:0] a
   );
      logic r;
      case (acc)
         3'd1:    r = a[0];
         3'd2:    r = (a != 2'b00);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dm_sba_lane.sv
// Byte-lane logic for one SBA beat (combinational).
// Ports: addr/size/wdata/rdata in; be, replicated wdata, extracted rdata, next address out.
module dm_sba_lane
   import dm_pkg::*;
(
   input  logic [31:0] addr_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_inc_o
);

   logic [31:0] rsh;

   assign rsh        = rdata_i >> {addr_i[1:0], 3'b000};
   assign addr_inc_o = addr_i + (32'd1 << size_i);

   always_comb begin
      be_o    = 4'hF;
      wdata_o = wdata_i;
      rdata_o = rsh;
      case (size_i)
         SZ_8: begin
            be_o    = 4'b0001 << addr_i[1:0];
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {24'h0, rsh[7:0]};
         end
         SZ_16: begin
            be_o    = 4'b0011 << addr_i[1:0];
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {16'h0, rsh[15:0]};
         end
         default: begin
            be_o    = 4'hF;
            wdata_o = wdata_i;
            rdata_o = rsh;
         end
      endcase
   end

endmodule

// File: rtl/dm_sba_master.sv
// SBA bus master: runs one single-beat transfer on a req/gnt/rvalid bus.
// Ports: front-end triggers/fields in, data/address/busy/error out; master_* bus side.
module dm_sba_master
   import dm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] sbaddress_i,
   input  logic [31:0] sbdata_i,
   input  logic [2:0]  sbaccess_i,
   input  logic        sbautoincrement_i,
   input  logic        sbreadonaddr_i,
   input  logic        sbreadondata_i,
   input  logic        sbaddress_write_valid_i,
   input  logic        sbdata_read_valid_i,
   input  logic        sbdata_write_valid_i,
   output logic [31:0] sbdata_o,
   output logic        sbdata_valid_o,
   output logic [31:0] sbaddress_o,
   output logic        sbaddress_update_o,
   output logic        sbbusy_o,
   output logic [2:0]  sberror_o,
   output logic        sberror_valid_o,
   output logic        master_req_o,
   output logic [31:0] master_add_o,
   output logic        master_we_o,
   output logic [31:0] master_wdata_o,
   output logic [3:0]  master_be_o,
   input  logic        master_gnt_i,
   input  logic        master_r_valid_i,
   input  logic [31:0] master_r_rdata_i,
   input  logic        master_r_err_i
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   sba_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, data_q;
   logic [1:0]  size_q;
   logic        inc_q, we_q;

   logic        wr_trig, rd_trig, cap, respond;
   logic        err_v_d, dv_d, au_d;
   sberror_e    err_d;

   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, lane_rdata, lane_inc;

   // A write trigger masks any read trigger in the same cycle.
   assign wr_trig = sbdata_write_valid_i;
   assign rd_trig = (sbaddress_write_valid_i & sbreadonaddr_i)
                  | (sbdata_read_valid_i & sbreadondata_i);

   dm_sba_lane u_lane (
      .addr_i     (addr_q),
      .size_i     (size_q),
      .wdata_i    (data_q),
      .rdata_i    (master_r_rdata_i),
      .be_o       (lane_be),
      .wdata_o    (lane_wdata),
      .rdata_o    (lane_rdata),
      .addr_inc_o (lane_inc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
      respond = 1'b0;
      err_v_d = 1'b0;
      err_d   = SBERR_NONE;
      dv_d    = 1'b0;
      au_d    = 1'b0;
      unique case (state_q)
         SBA_IDLE: begin
            if (wr_trig | rd_trig) begin
               if (sbaccess_i > 3'd2) begin
                  err_v_d = 1'b1;
                  err_d   = SBERR_SIZE;
               end else if (sba_misaligned(sbaccess_i, sbaddress_i[1:0])) begin
                  err_v_d = 1'b1;
                  err_d   = SBERR_ALIGN;
               end else begin
                  cap     = 1'b1;
                  cnt_d   = '0;
                  state_d = SBA_REQ;
               end
            end
         end
         SBA_REQ: begin
            if (master_gnt_i) begin
               cnt_d = '0;
               if (master_r_valid_i) begin
                  respond = 1'b1;
                  state_d = SBA_DONE;
               end else begin
                  state_d = SBA_WAIT;
               end
            end else if (cnt_q == TO_LAST) begin
               err_v_d = 1'b1;
               err_d   = SBERR_TIMEOUT;
               state_d = SBA_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SBA_WAIT: begin
            if (master_r_valid_i) begin
               respond = 1'b1;
               state_d = SBA_DONE;
            end else if (cnt_q == TO_LAST) begin
               err_v_d = 1'b1;
               err_d   = SBERR_TIMEOUT;
               state_d = SBA_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SBA_DONE: state_d = SBA_IDLE;
         default:  state_d = SBA_IDLE;
      endcase
      // Result pulses are registered, so they land in DONE.
      if (respond) begin
         if (master_r_err_i) begin
            err_v_d = 1'b1;
            err_d   = SBERR_BADADDR;
         end else begin
            dv_d = ~we_q;
            au_d = inc_q;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q            <= SBA_IDLE;
         cnt_q              <= '0;
         addr_q             <= '0;
         data_q             <= '0;
         size_q             <= '0;
         inc_q              <= 1'b0;
         we_q               <= 1'b0;
         sbdata_o           <= '0;
         sbdata_valid_o     <= 1'b0;
         sbaddress_o        <= '0;
         sbaddress_update_o <= 1'b0;
         sberror_o          <= '0;
         sberror_valid_o    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (cap) begin
            addr_q <= sbaddress_i;
            data_q <= sbdata_i;
            size_q <= sbaccess_i[1:0];
            inc_q  <= sbautoincrement_i;
            we_q   <= wr_trig;
         end
         sbdata_valid_o <= dv_d;
         if (dv_d) sbdata_o <= lane_rdata;
         sbaddress_update_o <= au_d;
         if (au_d) sbaddress_o <= lane_inc;
         sberror_valid_o <= err_v_d;
         sberror_o       <= err_d;
      end
   end

   // Bus fields are forced to 0 outside REQ so nothing stale leaks out.
   assign sbbusy_o       = (state_q != SBA_IDLE);
   assign master_req_o   = (state_q == SBA_REQ);
   assign master_add_o   = master_req_o ? {addr_q[31:2], 2'b00} : '0;
   assign master_we_o    = master_req_o & we_q;
   assign master_wdata_o = master_req_o ? lane_wdata : '0;
   assign master_be_o    = master_req_o ? lane_be : '0;

endmodule

// File: tb/tb_dm_sba_master.sv
// Self-checking bench for dm_sba_master.
// Directed plan steps plus randomized transfers against a spec-level model.
module tb_dm_sba_master;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sbaddress_i, sbdata_i;
   logic [2:0]  sbaccess_i;
   logic        sbautoincrement_i, sbreadonaddr_i, sbreadondata_i;
   logic        sbaddress_write_valid_i, sbdata_read_valid_i;
   logic        sbdata_write_valid_i;
   logic [31:0] sbdata_o, sbaddress_o;
   logic        sbdata_valid_o, sbaddress_update_o, sbbusy_o;
   logic [2:0]  sberror_o;
   logic        sberror_valid_o;
   logic        master_req_o, master_we_o;
   logic [31:0] master_add_o, master_wdata_o;
   logic [3:0]  master_be_o;
   logic        master_gnt_i, master_r_valid_i, master_r_err_i;
   logic [31:0] master_r_rdata_i;

   int n_chk = 0;
   int n_pass = 0;

   dm_sba_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .sbaddress_i             (sbaddress_i),
      .sbdata_i                (sbdata_i),
      .sbaccess_i              (sbaccess_i),
      .sbautoincrement_i       (sbautoincrement_i),
      .sbreadonaddr_i          (sbreadonaddr_i),
      .sbreadondata_i          (sbreadondata_i),
      .sbaddress_write_valid_i (sbaddress_write_valid_i),
      .sbdata_read_valid_i     (sbdata_read_valid_i),
      .sbdata_write_valid_i    (sbdata_write_valid_i),
      .sbdata_o                (sbdata_o),
      .sbdata_valid_o          (sbdata_valid_o),
      .sbaddress_o             (sbaddress_o),
      .sbaddress_update_o      (sbaddress_update_o),
      .sbbusy_o                (sbbusy_o),
      .sberror_o               (sberror_o),
      .sberror_valid_o         (sberror_valid_o),
      .master_req_o            (master_req_o),
      .master_add_o            (master_add_o),
      .master_we_o             (master_we_o),
      .master_wdata_o          (master_wdata_o),
      .master_be_o             (master_be_o),
      .master_gnt_i            (master_gnt_i),
      .master_r_valid_i        (master_r_valid_i),
      .master_r_rdata_i        (master_r_rdata_i),
      .master_r_err_i          (master_r_err_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One transfer: drive the trigger, act as the bus slave, then
   // compare what was seen against the expected outcome.
   task automatic xfer(input bit we, input bit both, input bit inj,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int acc, input bit inc,
                       input int gdly, input int rdly,
                       input logic [31:0] rdata, input bit rerr);
      int nb, off, e_busy, e_req, e_eidx;
      bit bad_sz, bad_al, e_ep, e_dv, e_au;
      logic [2:0]  e_err;
      logic [63:0] m;
      logic [31:0] e_rd, e_wd, e_inc;
      logic [3:0]  e_be;
      int n_busy, n_req, n_err, e_idx, n_dv, dv_idx, n_au, k;
      logic [2:0]  err_code;
      logic [31:0] dv_data, au_addr, b_add, b_wd;
      logic [3:0]  b_be;
      logic        b_we;
      bit granted, responded;

      // expected outcome from the access rules
      bad_sz = (acc > 2);
      nb  = bad_sz ? 4 : (1 << acc);
      off = int'(addr[1:0]);
      bad_al = !bad_sz && ((int'(addr[1:0]) % nb) != 0);
      e_dv = 0;
      e_au = 0;
      e_err = 3'd0;
      if (bad_sz || bad_al) begin
         e_busy = 0; e_req = 0; e_ep = 1; e_eidx = 1;
         e_err = bad_sz ? 3'd4 : 3'd3;
      end else if (gdly >= TO) begin
         e_busy = TO; e_req = TO; e_ep = 1; e_eidx = TO + 1;
         e_err = 3'd1;
      end else if (rdly > TO) begin
         e_busy = gdly + 1 + TO; e_req = gdly + 1; e_ep = 1;
         e_eidx = e_busy + 1; e_err = 3'd1;
      end else begin
         e_busy = gdly + rdly + 2; e_req = gdly + 1;
         e_ep = rerr; e_eidx = e_busy; e_err = 3'd2;
         e_dv = !we && !rerr;
         e_au = inc && !rerr;
      end
      m     = (64'd1 << (8 * nb)) - 64'd1;
      e_rd  = 32'((64'(rdata) >> (8 * off)) & m);
      e_be  = 4'(((1 << nb) - 1) << off);
      e_inc = addr + 32'(nb);
      if (nb == 1)      e_wd = {24'h0, data[7:0]} * 32'h01010101;
      else if (nb == 2) e_wd = {16'h0, data[15:0]} * 32'h00010001;
      else              e_wd = data;

      n_busy = 0; n_req = 0; n_err = 0; n_dv = 0; n_au = 0; k = 0;
      e_idx = 0; dv_idx = 0; err_code = 0; dv_data = 0; au_addr = 0;
      b_add = 0; b_wd = 0; b_be = 0; b_we = 0;
      granted = 0; responded = 0;

      @(negedge clk);
      sbaddress_i = addr;
      sbdata_i = data;
      sbaccess_i = 3'(acc);
      sbautoincrement_i = inc;
      sbreadonaddr_i = 1'b1;
      sbreadondata_i = 1'b1;
      master_r_rdata_i = rdata;
      if (we) begin
         sbdata_write_valid_i = 1'b1;
         if (both) sbaddress_write_valid_i = 1'b1;
      end else if ($urandom_range(1) == 1) begin
         sbaddress_write_valid_i = 1'b1;
      end else begin
         sbdata_read_valid_i = 1'b1;
      end

      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) begin
            sbdata_write_valid_i = 0;
            sbaddress_write_valid_i = 0;
            sbdata_read_valid_i = 0;
            sbaddress_i = $urandom;
            sbdata_i = $urandom;
            sbaccess_i = 3'($urandom_range(2));
         end
         sbdata_read_valid_i = (inj && c == 2);
         if (sbbusy_o) n_busy++;
         if (sberror_valid_o) begin
            n_err++;
            if (n_err == 1) begin err_code = sberror_o; e_idx = c; end
         end
         if (sbdata_valid_o) begin
            n_dv++;
            if (n_dv == 1) begin dv_data = sbdata_o; dv_idx = c; end
         end
         if (sbaddress_update_o) begin
            n_au++;
            if (n_au == 1) au_addr = sbaddress_o;
         end
         master_gnt_i = 0;
         master_r_valid_i = 0;
         if (granted && !responded) begin
            k++;
            if (k == rdly) begin master_r_valid_i = 1; responded = 1; end
         end
         if (master_req_o) begin
            n_req++;
            if (n_req == 1) begin
               b_add = master_add_o; b_be = master_be_o;
               b_we = master_we_o; b_wd = master_wdata_o;
            end
            if (!granted && n_req == gdly + 1) begin
               master_gnt_i = 1;
               granted = 1;
               if (rdly == 0) begin master_r_valid_i = 1; responded = 1; end
            end
         end
         master_r_err_i = master_r_valid_i & rerr;
      end
      master_gnt_i = 0;
      master_r_valid_i = 0;
      master_r_err_i = 0;
      sbdata_read_valid_i = 0;

      chk("busy_cycles", 32'(n_busy), 32'(e_busy));
      chk("req_cycles", 32'(n_req), 32'(e_req));
      chk("err_pulses", 32'(n_err), 32'(e_ep));
      if (e_ep) begin
         chk("err_code", 32'(err_code), 32'(e_err));
         chk("err_cycle", 32'(e_idx), 32'(e_eidx));
      end
      chk("data_pulses", 32'(n_dv), 32'(e_dv));
      if (e_dv) begin
         chk("rdata", dv_data, e_rd);
         chk("rdata_cycle", 32'(dv_idx), 32'(e_busy));
      end
      chk("addr_updates", 32'(n_au), 32'(e_au));
      if (e_au) chk("addr_inc", au_addr, e_inc);
      if (e_req > 0) begin
         chk("bus_add", b_add, {addr[31:2], 2'b00});
         chk("bus_be", 32'(b_be), 32'(e_be));
         chk("bus_we", 32'(b_we), 32'(we));
         if (we) chk("bus_wdata", b_wd, e_wd);
      end
   endtask

   initial begin
      int n_dv, n_busy;
      bit we, inc, rerr;
      int acc, g, r;
      logic [31:0] a;

      rst = 1;
      sbaddress_i = 0; sbdata_i = 0; sbaccess_i = 0;
      sbautoincrement_i = 0; sbreadonaddr_i = 0; sbreadondata_i = 0;
      sbaddress_write_valid_i = 0; sbdata_read_valid_i = 0;
      sbdata_write_valid_i = 0;
      master_gnt_i = 0; master_r_valid_i = 0; master_r_err_i = 0;
      master_r_rdata_i = 0;
      repeat (3) @(negedge clk);
      chk("rst_sbdata", sbdata_o, 32'h0);
      chk("rst_sbaddress", sbaddress_o, 32'h0);
      chk("rst_flags", {26'h0, sbdata_valid_o, sbaddress_update_o,
          sbbusy_o, sberror_valid_o, master_req_o, master_we_o}, 32'h0);
      chk("rst_err", 32'(sberror_o), 32'h0);
      chk("rst_bus", master_add_o | master_wdata_o | 32'(master_be_o), 32'h0);
      rst = 0;

      xfer(1, 0, 0, 32'h00100000, 32'hAABBCCDD, 2, 0, 0, 1, 0, 0);
      xfer(0, 0, 0, 32'h00100003, 32'h0, 0, 1, 0, 1, 32'h11223344, 0);
      xfer(0, 0, 0, 32'h00100001, 32'h0, 1, 0, 0, 1, 32'h0, 0);
      xfer(0, 0, 0, 32'h00100000, 32'h0, 3, 0, 0, 1, 32'h0, 0);
      xfer(0, 0, 0, 32'h00100000, 32'h0, 2, 0, 20, 0, 32'h0, 0);
      xfer(0, 0, 0, 32'h00100008, 32'h0, 2, 1, 0, 1, 32'h12345678, 1);
      xfer(1, 1, 1, 32'h00100006, 32'h0000BEEF, 1, 0, 1, 2, 32'h0, 0);
      xfer(0, 0, 0, 32'h00100004, 32'h0, 2, 0, 0, 12, 32'h0, 0);
      xfer(0, 0, 0, 32'h00100002, 32'h0, 1, 0, 0, 0, 32'hCAFE0000, 0);
      xfer(1, 0, 0, 32'hFFFFFFFC, 32'h01020304, 2, 1, 2, 3, 32'h0, 0);

      // reset while waiting for the response
      @(negedge clk);
      sbaddress_i = 32'h00100010; sbaccess_i = 3'd2;
      sbaddress_write_valid_i = 1; sbreadonaddr_i = 1;
      @(negedge clk);
      sbaddress_write_valid_i = 0;
      master_gnt_i = 1;
      @(negedge clk);
      master_gnt_i = 0;
      chk("wait_busy", 32'(sbbusy_o), 32'h1);
      rst = 1;
      #1;
      chk("midrst_flags", {27'h0, sbbusy_o, master_req_o, sbdata_valid_o,
          sbaddress_update_o, sberror_valid_o}, 32'h0);
      chk("midrst_bus", master_add_o | 32'(master_be_o), 32'h0);
      @(negedge clk);
      rst = 0;
      master_r_valid_i = 1;
      master_r_rdata_i = 32'h55AA55AA;
      n_dv = 0; n_busy = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         master_r_valid_i = 0;
         n_dv += int'(sbdata_valid_o);
         n_busy += int'(sbbusy_o);
      end
      chk("late_rvalid_dv", 32'(n_dv), 32'h0);
      chk("late_rvalid_busy", 32'(n_busy), 32'h0);

      for (int i = 0; i < 24; i++) begin
         we   = 1'($urandom_range(1));
         inc  = 1'($urandom_range(1));
         rerr = ($urandom_range(7) == 0);
         acc  = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
         g    = int'($urandom_range(4));
         r    = int'($urandom_range(4));
         a    = $urandom;
         if ($urandom_range(3) != 0 && acc < 3)
            a = a & ~((32'd1 << acc) - 32'd1);
         xfer(we, 0, 0, a, $urandom, acc, inc, g, r, $urandom, rerr);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
